// File: rtl/nbin_bit_serializer_pkg.sv
// Shared defaults, FSM state type and precision clamp for the bit-serial neuron feeder.
// Optional shadow buffer is enabled by defining NBIN_SER_DBUF_EN.
package nbin_bit_serializer_pkg;

    localparam int unsigned N_DEF       = 16;
    localparam int unsigned TI_DEF      = 16;
    localparam int unsigned TW_DEF      = 16;
    localparam int unsigned PREC_W_DEF  = 5;
    localparam int unsigned NFU_LAT_DEF = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    // Zero or out-of-range precision means full width.
    function automatic int unsigned clamp_prec(input int unsigned p, input int unsigned n);
        return ((p == 0) || (p > n)) ? n : p;
    endfunction

endpackage

// File: rtl/nbin_bit_serializer_if.sv
// Brick handshake and bit-plane output bundle between the brick source and the serializer.
interface nbin_bit_serializer_if
    import nbin_bit_serializer_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned Ti     = TI_DEF,
    parameter int unsigned Tw     = TW_DEF,
    parameter int unsigned PREC_W = PREC_W_DEF
);
    logic                  i_valid;
    logic                  o_ready;
    logic [Tw*Ti*N-1:0]    i_neurons;
    logic [PREC_W-1:0]     i_precision;
    logic [Tw*Ti-1:0]      o_neurons;
    logic                  o_first_cycle;
    logic                  o_last_cycle;
    logic                  o_busy;
    logic                  o_acc_valid;

    modport master (
        output i_valid, i_neurons, i_precision,
        input  o_ready, o_neurons, o_first_cycle, o_last_cycle, o_busy, o_acc_valid
    );

    modport slave (
        input  i_valid, i_neurons, i_precision,
        output o_ready, o_neurons, o_first_cycle, o_last_cycle, o_busy, o_acc_valid
    );
endinterface

// File: rtl/nbin_bit_serializer_bit_select.sv
// Combinational bit-plane extractor: bit k of every neuron in the brick, one lane per neuron.
module nbin_bit_select #(
    parameter int unsigned N     = 16,
    parameter int unsigned LANES = 256,
    parameter int unsigned KW    = 5
) (
    input  logic [LANES*N-1:0] data_i,
    input  logic [KW-1:0]      k_i,
    output logic [LANES-1:0]   plane_o
);
    always_comb begin
        plane_o = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            plane_o[j] = data_i[N*j + 32'(k_i)];
        end
    end
endmodule

// File: rtl/nbin_bit_serializer.sv
// Bit-serial brick feeder: IDLE/SHIFT FSM, active (and optional shadow) buffer, plane counter,
// and the accumulator-valid delay line. Define NBIN_SER_DBUF_EN for the one-brick shadow buffer.
module nbin_bit_serializer
    import nbin_bit_serializer_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned Ti      = TI_DEF,
    parameter int unsigned Tw      = TW_DEF,
    parameter int unsigned PREC_W  = PREC_W_DEF,
    parameter int unsigned NFU_LAT = NFU_LAT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    nbin_bit_serializer_if.slave  bus
);
    localparam int unsigned LANES = Tw * Ti;
    localparam int unsigned BW    = LANES * N;

    ser_state_e         state_q, state_d;
    logic [PREC_W-1:0]  k_q, k_d;
    logic [PREC_W-1:0]  p_q, p_d;
    logic [BW-1:0]      act_q, act_d;
    logic [NFU_LAT-1:0] acc_dly_q, acc_dly_d;

    logic               ready;
    logic               accept;
    logic               load_direct;
    logic               busy;
    logic               last_cycle;
    logic [PREC_W-1:0]  p_in;
    logic [LANES-1:0]   plane;

`ifdef NBIN_SER_DBUF_EN
    logic [BW-1:0]      shd_q, shd_d;
    logic [PREC_W-1:0]  shd_p_q, shd_p_d;
    logic               shd_full_q, shd_full_d;

    assign ready = ~shd_full_q;
`else
    assign ready = (state_q == ST_IDLE) | (k_q == '0);
`endif

    assign accept      = bus.i_valid & ready;
    assign load_direct = accept & ((state_q == ST_IDLE) | (k_q == '0));
    assign p_in        = PREC_W'(clamp_prec(32'(bus.i_precision), N));
    assign busy        = (state_q == ST_SHIFT);
    assign last_cycle  = busy & (k_q == '0);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        p_d     = p_q;
        act_d   = act_q;
`ifdef NBIN_SER_DBUF_EN
        shd_d      = shd_q;
        shd_p_d    = shd_p_q;
        shd_full_d = shd_full_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SHIFT;
                    act_d   = bus.i_neurons;
                    p_d     = p_in;
                    k_d     = p_in - PREC_W'(1);
                end
            end
            ST_SHIFT: begin
                if (k_q != '0) begin
                    k_d = k_q - PREC_W'(1);
                end else if (accept) begin
                    act_d = bus.i_neurons;
                    p_d   = p_in;
                    k_d   = p_in - PREC_W'(1);
`ifdef NBIN_SER_DBUF_EN
                end else if (shd_full_q) begin
                    act_d      = shd_q;
                    p_d        = shd_p_q;
                    k_d        = shd_p_q - PREC_W'(1);
                    shd_full_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef NBIN_SER_DBUF_EN
        // A brick arriving mid-shift parks in the shadow until the active brick hits plane 0.
        if (accept && !load_direct) begin
            shd_d      = bus.i_neurons;
            shd_p_d    = p_in;
            shd_full_d = 1'b1;
        end
`endif
    end

    always_comb begin
        acc_dly_d    = acc_dly_q;
        acc_dly_d[0] = last_cycle;
        for (int unsigned i = 1; i < NFU_LAT; i++) begin
            acc_dly_d[i] = acc_dly_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            p_q       <= '0;
            act_q     <= '0;
            acc_dly_q <= '0;
`ifdef NBIN_SER_DBUF_EN
            shd_q      <= '0;
            shd_p_q    <= '0;
            shd_full_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            p_q       <= p_d;
            act_q     <= act_d;
            acc_dly_q <= acc_dly_d;
`ifdef NBIN_SER_DBUF_EN
            shd_q      <= shd_d;
            shd_p_q    <= shd_p_d;
            shd_full_q <= shd_full_d;
`endif
        end
    end

    nbin_bit_select #(
        .N     (N),
        .LANES (LANES),
        .KW    (PREC_W)
    ) u_bit_select (
        .data_i  (act_q),
        .k_i     (k_q),
        .plane_o (plane)
    );

    assign bus.o_ready       = ready;
    assign bus.o_busy        = busy;
    assign bus.o_neurons     = busy ? plane : '0;
    assign bus.o_first_cycle = busy & (k_q == (p_q - PREC_W'(1)));
    assign bus.o_last_cycle  = last_cycle;
    assign bus.o_acc_valid   = acc_dly_q[NFU_LAT-1];

endmodule

// File: tb/tb_nbin_bit_serializer.sv
// Self-checking bench for nbin_bit_serializer: per-cycle timeline model of scheduled bricks.
module tb_nbin_bit_serializer;
    localparam int N    = 16;
    localparam int TI   = 16;
    localparam int TW   = 16;
    localparam int PW   = 5;
    localparam int LAT  = 2;
    localparam int NP   = TW * TI;
    localparam int NB   = NP * N;
    localparam int MAXC = 2048;

    logic clk = 1'b0;
    logic reset = 1'b0;

    nbin_bit_serializer_if #(.N(N), .Ti(TI), .Tw(TW), .PREC_W(PW)) bus ();

    nbin_bit_serializer #(
        .N(N), .Ti(TI), .Tw(TW), .PREC_W(PW), .NFU_LAT(LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    bit last_accept = 1'b0;

    // Expected outputs per period (period c = interval after the c-th rising edge).
    logic [NP-1:0] exp_plane [MAXC];
    bit            exp_first [MAXC];
    bit            exp_last  [MAXC];
    bit            exp_busy  [MAXC];
    bit            exp_acc   [MAXC];
    int            sched_end;
    int            pending_start;

    function automatic bit model_ready(input int c);
`ifdef NBIN_SER_DBUF_EN
        return pending_start <= c;
`else
        return sched_end <= c;
`endif
    endfunction

    task automatic clear_from(input int c);
        for (int i = c; i < MAXC; i++) begin
            exp_plane[i] = '0;
            exp_first[i] = 1'b0;
            exp_last[i]  = 1'b0;
            exp_busy[i]  = 1'b0;
            exp_acc[i]   = 1'b0;
        end
        sched_end     = -1;
        pending_start = 0;
    endtask

    // Brick accepted at edge e occupies P periods starting when the previous brick ends.
    task automatic schedule(input logic [NB-1:0] d, input logic [PW-1:0] praw, input int e);
        int p;
        int s;
        p = (praw == 0 || int'(praw) > N) ? N : int'(praw);
        s = (sched_end + 1 > e) ? sched_end + 1 : e;
        if (s > e) pending_start = s;
        for (int j = 0; j < p; j++) begin
            int k;
            k = p - 1 - j;
            if (s + j < MAXC) begin
                for (int b = 0; b < NP; b++) exp_plane[s+j][b] = d[N*b + k];
                exp_busy[s+j]  = 1'b1;
                exp_first[s+j] = (j == 0);
                exp_last[s+j]  = (j == p - 1);
            end
        end
        if (s + p - 1 + LAT < MAXC) exp_acc[s+p-1+LAT] = 1'b1;
        sched_end = s + p - 1;
    endtask

    task automatic chk(input string tag, input logic [NP-1:0] obs, input logic [NP-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("ready",   NP'(bus.o_ready),       NP'(model_ready(cyc)));
        chk("neurons", bus.o_neurons,          exp_plane[cyc]);
        chk("first",   NP'(bus.o_first_cycle), NP'(exp_first[cyc]));
        chk("last",    NP'(bus.o_last_cycle),  NP'(exp_last[cyc]));
        chk("busy",    NP'(bus.o_busy),        NP'(exp_busy[cyc]));
        chk("acc",     NP'(bus.o_acc_valid),   NP'(exp_acc[cyc]));
    endtask

    task automatic tick();
        bit acc;
        @(negedge clk);
        check_outputs();
        acc = (bus.i_valid === 1'b1) && (reset === 1'b1) && model_ready(cyc);
        @(posedge clk);
        cyc++;
        last_accept = acc;
        if (acc) schedule(bus.i_neurons, bus.i_precision, cyc);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [NB-1:0] d, input logic [PW-1:0] p);
        int waited;
        waited = 0;
        bus.i_valid     = 1'b1;
        bus.i_neurons   = d;
        bus.i_precision = p;
        do begin
            tick();
            waited++;
        end while (!last_accept && waited < 200);
        if (!last_accept) begin
            ncmp++;
            nfail++;
            $error("FAIL send_timeout cyc=%0d observed=no_accept expected=accept", cyc);
        end
        bus.i_valid = 1'b0;
    endtask

    function automatic logic [NB-1:0] rand_brick();
        logic [NB-1:0] r;
        for (int w = 0; w < NB / 32; w++) r[32*w +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
        $fatal(1);
    end

    initial begin
        logic [NB-1:0] d;
        bus.i_valid     = 1'b0;
        bus.i_neurons   = '0;
        bus.i_precision = '0;
        clear_from(0);

        // Reset state.
        idle(2);
        reset = 1'b1;
        idle(2);

        // Single full-precision brick: sign bit and LSB of neuron 0 only.
        d = '0;
        d[15:0] = 16'h8001;
        send(d, 5'd16);
        idle(20);

        // P=4: only the low nibble of neuron (3,5) may appear.
        d = rand_brick();
        d[N*53 +: 4] = 4'b1010;
        send(d, 5'd4);
        idle(8);

        // P=1 and P=0 (clamped to full width).
        send(rand_brick(), 5'd1);
        idle(4);
        send(rand_brick(), 5'd0);
        idle(20);

        // i_valid held through the active brick: next one follows the last plane.
        send(rand_brick(), 5'd5);
        send(rand_brick(), 5'd3);
        idle(8);

        // Three back-to-back bricks with i_valid held throughout.
        send(rand_brick(), 5'd3);
        send(rand_brick(), 5'd5);
        send(rand_brick(), 5'd2);
        idle(10);

        // Asynchronous reset while plane 7 of a P=16 brick is on the outputs.
        send(rand_brick(), 5'd16);
        idle(8);
        reset = 1'b0;
        #1;
        clear_from(cyc);
        check_outputs();
        idle(3);
        reset = 1'b1;
        idle(2);
        send(rand_brick(), 5'd16);
        idle(20);

        // Randomized bricks and precisions, including out-of-range ones.
        for (int n = 0; n < 12; n++) begin
            send(rand_brick(), PW'($urandom_range(0, 31)));
            idle(int'($urandom_range(0, 3)));
        end
        idle(25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
